// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int unsigned DIV_MIN = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int unsigned half_ceil(input int unsigned n);
        return (n + 1) / 2;
    endfunction

    function automatic bit div_legal(input int unsigned n, input int unsigned w);
        return (n >= DIV_MIN) && (n <= ((32'd1 << w) - 32'd1));
    endfunction

endpackage

// File: rtl/clk_div_oddphase.sv
// Negedge half-phase flop and output select; the only falling-edge logic in the divider.
module clk_div_oddphase (
    input  logic clock,
    input  logic reset,
    input  logic i_clk_pos,
    input  logic i_odd,
    output logic o_clk_out
);

    logic r_clk_neg;

    always_ff @(negedge clock) begin
        if (reset) r_clk_neg <= 1'b0;
        else       r_clk_neg <= i_clk_pos;
    end

    // Odd divisors: AND with the half-cycle delayed copy trims the high phase to N/2.
    assign o_clk_out = i_odd ? (i_clk_pos & r_clk_neg) : i_clk_pos;

endmodule

// File: rtl/clk_div_n.sv
// Runtime-programmable 50%-duty clock divider with a same-domain tick enable.
module clk_div_n
    import clk_div_pkg::*;
#(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 3,
    parameter int AUTO_RUN    = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] div_in,
    input  logic         div_load,
    output logic         clk_out,
    output logic         tick,
    output logic         busy,
    output logic         div_err
);

    generate
        if (!div_legal(DEFAULT_DIV, W)) begin : g_bad_default
            $error("clk_div_n: DEFAULT_DIV outside 2..2^W-1");
        end
    endgenerate

    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_cnt, r_div_q, r_pend_q;
    logic         r_pend_valid, r_clk_pos, r_tick, r_div_err;

    logic [W-1:0] w_cnt_nxt, w_cnt_inc, w_half;
    logic         w_tick_nxt, w_pos_nxt, w_wrap, w_bnd, w_start;
    logic         w_load_ok, w_load_bad;

    assign w_cnt_inc  = r_cnt + W'(1);
    assign w_half     = W'(half_ceil(32'(r_div_q)));
    assign w_wrap     = (r_state == ST_RUN) && (r_cnt == r_div_q - W'(1));
    assign w_bnd      = (r_state == ST_IDLE) || w_wrap;
    assign w_start    = en && ((AUTO_RUN != 0) || r_pend_valid);
    assign w_load_ok  = div_load && (div_in >= W'(DIV_MIN));
    assign w_load_bad = div_load && (div_in <  W'(DIV_MIN));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_tick_nxt  = 1'b0;
        w_pos_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_RUN;
                    w_tick_nxt  = 1'b1;
                    w_pos_nxt   = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_wrap) begin
                    // A dropped en only ends the run here, so no pulse is ever truncated.
                    if (en) begin
                        w_tick_nxt = 1'b1;
                        w_pos_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_pos_nxt = (w_cnt_inc < w_half);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_div_q      <= W'(DEFAULT_DIV);
            r_pend_q     <= '0;
            r_pend_valid <= 1'b0;
            r_clk_pos    <= 1'b0;
            r_tick       <= 1'b0;
            r_div_err    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_clk_pos <= w_pos_nxt;
            r_tick    <= w_tick_nxt;
            r_div_err <= w_load_bad;
            // Apply the old pending value first; a same-cycle load then becomes the new pending one.
            if (w_bnd && r_pend_valid) begin
                r_div_q      <= r_pend_q;
                r_pend_valid <= 1'b0;
            end
            if (w_load_ok) begin
                r_pend_q     <= div_in;
                r_pend_valid <= 1'b1;
            end
        end
    end

    clk_div_oddphase u_oddphase (
        .clock     (clock),
        .reset     (reset),
        .i_clk_pos (r_clk_pos),
        .i_odd     (r_div_q[0]),
        .o_clk_out (clk_out)
    );

    assign tick    = r_tick;
    assign busy    = (r_state == ST_RUN);
    assign div_err = r_div_err;

endmodule

// File: tb/tb_clk_div_n.sv
// Directed plus random bench for clk_div_n against a period-level reference model.
module tb_clk_div_n;

    localparam int W   = 8;
    localparam int DEF = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         div_load = 1'b0;
    logic         clk_out, tick, busy, div_err;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: position within the current period, active divisor, pending divisor.
    int m_p = 0;
    int m_div = DEF;
    int m_pend = 0;
    bit m_run = 0, m_pv = 0, m_tick = 0, m_err = 0;

    clk_div_n #(.W(W), .DEFAULT_DIV(DEF), .AUTO_RUN(1)) dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy),
        .div_err  (div_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int din;
        int nd;
        bit npv;
        din = int'(div_in);
        if (reset) begin
            m_run = 0; m_p = 0; m_div = DEF; m_pv = 0; m_err = 0; m_tick = 0;
        end else begin
            m_err = div_load && (din < 2);
            nd  = m_div;
            npv = m_pv;
            if ((!m_run || m_p == m_div - 1) && m_pv) begin
                nd  = m_pend;
                npv = 0;
            end
            if (div_load && din >= 2) begin
                m_pend = din;
                npv    = 1;
            end
            if (!m_run) begin
                if (en) begin m_run = 1; m_p = 0; end
            end else if (m_p == m_div - 1) begin
                m_p = 0;
                if (!en) m_run = 0;
            end else begin
                m_p++;
            end
            m_div  = nd;
            m_pv   = npv;
            m_tick = m_run && (m_p == 0);
        end
    endtask

    // Output is high for exactly N half-cycles per period; odd N starts half a cycle late.
    function automatic logic exp_out(input int half);
        int h, o;
        if (!m_run) return 1'b0;
        h = 2 * m_p + half;
        o = m_div % 2;
        return (h >= o) && (h - o < m_div);
    endfunction

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("tick", tick, m_tick);
        chk("busy", busy, m_run);
        chk("div_err", div_err, m_err);
        chk("clk_out_first_half", clk_out, exp_out(0));
        @(negedge clock);
        #1;
        chk("clk_out_second_half", clk_out, exp_out(1));
    endtask

    task automatic load(input int n);
        div_in   = W'(n);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
    endtask

    task automatic wait_phase(input int div, input int p);
        bit reached;
        reached = 0;
        for (int k = 0; k < 800; k++) begin
            if (m_run && m_div == div && m_p == p) begin
                reached = 1;
                break;
            end
            step();
        end
        vectors++;
        assert (reached) else begin
            miscompares++;
            $error("FAIL wait_phase: N=%0d cnt=%0d observed unreached expected reached", div, p);
        end
    endtask

    initial begin
        int sweep[4] = '{2, 5, 8, 255};

        // Reset state
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();

        // Default divide-by-3
        en = 1'b1;
        repeat (12) step();

        // Change to 4 mid-period
        wait_phase(3, 1);
        load(4);
        repeat (16) step();

        // Divisor sweep
        foreach (sweep[i]) begin
            load(sweep[i]);
            repeat (3 * sweep[i] + 12) step();
        end

        // Illegal loads leave the divisor alone
        load(3);
        repeat (6) step();
        load(0);
        step();
        load(1);
        repeat (9) step();

        // Stop at cnt=1 of N=5, then restart
        load(5);
        wait_phase(5, 1);
        en = 1'b0;
        repeat (10) step();
        en = 1'b1;
        repeat (12) step();

        // Reset at cnt=2 of N=7
        load(7);
        wait_phase(7, 2);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (20) step();

        // Randomized en/load traffic
        repeat (500) begin
            en       = ($urandom_range(0, 11) != 0);
            div_load = ($urandom_range(0, 13) == 0);
            div_in   = W'($urandom_range(0, 12));
            step();
        end
        div_load = 1'b0;
        en = 1'b1;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
